mcp_scan_avg: RTL and testbench

Parametrised MCP3008 scan controller. It replaces the single-shot MCP3008 reader behind `cmd_get_mcp`. It scans channels 0..N_CH-1, either single-shot or continuously, and averages 2^AVG_LOG2 conversions per channel. Each averaged result is delivered on a valid/ready stream, which feeds the FT245 transmit path and the Peltier regulation logic.

---
 rtl/mcp_scan_avg_if.sv | 10 +
 rtl/mcp_scan_avg.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mcp_scan_avg.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp_scan_avg_if.sv
// Result stream of the MCP3008 scan controller.
// The master drives the averaged result with its valid flag; the slave returns ready.
interface mcp_scan_avg_if;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;

   modport master (output res_data, output res_valid, input res_ready);
   modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/mcp_scan_avg.sv
// MCP3008 scan controller.
// Scans channels 0..N_CH-1, either single-shot or continuously. Each channel is
// converted 2^AVG_LOG2 times and the truncated mean is delivered on a
// valid/ready stream as {ch[2:0], 3'b000, avg[9:0]}.
// A result that arrives while the previous one is still unaccepted is dropped,
// and the sticky overrun flag is set. Scanning never stalls for the consumer.
module mcp_scan_avg #(
   parameter int   CLK_DIV     = 4,
   parameter int   N_CH        = 8,
   parameter int   AVG_LOG2    = 2,
   parameter int   CS_HIGH_CYC = 8,
   parameter logic SGL_DIFF    = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            continuous,
   input  logic            stop,
   output logic            busy,
   output logic            mcp_cs_n,
   output logic            mcp_dclk,
   output logic            mcp_din,
   input  logic            mcp_dout,
   output logic            overrun,
   mcp_scan_avg_if.master  res
);

   localparam int          ACC_W     = 10 + AVG_LOG2;
   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] CSH_LAST  = 16'(CS_HIGH_CYC - 1);
   localparam logic [2:0]  LAST_CH   = 3'(N_CH - 1);
   localparam logic [4:0]  LAST_CONV = 5'((1 << AVG_LOG2) - 1);
   // 17 DCLK periods = 34 half periods; even halves are low, odd halves are high.
   localparam logic [5:0]  LAST_HALF = 6'd33;
   // High half of period 8 carries B9, the first data bit.
   localparam logic [5:0]  FIRST_CAP = 6'd15;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CS_HIGH  = 3'd3,
      ST_ACCUM    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [5:0]         half_q, half_d;
   logic [4:0]         conv_q, conv_d;
   logic [2:0]         ch_q, ch_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [9:0]         shift_q, shift_d;
   logic               cont_q, cont_d;
   logic               stop_req_q, stop_req_d;
   logic               cs_n_q, cs_n_d;
   logic               dclk_q, dclk_d;
   logic               din_q, din_d;
   logic               busy_q, busy_d;
   logic [15:0]        res_data_q, res_data_d;
   logic               res_valid_q, res_valid_d;
   logic               overrun_q, overrun_d;
   logic               sync1_q, sync2_q;
   logic [9:0]         avg_s;

   // Command bit sent to the ADC in DCLK period 1..17.
   function automatic logic din_bit(input logic [4:0] period, input logic [2:0] ch);
      logic b;
      case (period)
         5'd1:    b = 1'b1;
         5'd2:    b = SGL_DIFF;
         5'd3:    b = ch[2];
         5'd4:    b = ch[1];
         5'd5:    b = ch[0];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   // Truncating mean: the accumulator holds exactly 2^AVG_LOG2 samples.
   assign avg_s = acc_q[AVG_LOG2 +: 10];

   // Two-flop synchroniser for the ADC data line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= mcp_dout;
         sync2_q <= sync1_q;
      end
   end

   // Next-state, serial-frame and result-stream logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 16'd1;
      half_d      = half_q;
      conv_d      = conv_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      shift_d     = shift_q;
      cont_d      = cont_q;
      stop_req_d  = stop_req_q | stop;
      cs_n_d      = cs_n_q;
      dclk_d      = dclk_q;
      din_d       = din_q;
      res_data_d  = res_data_q;
      overrun_d   = overrun_q;
      if (res_valid_q && res.res_ready) begin
         res_valid_d = 1'b0;
      end else begin
         res_valid_d = res_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            stop_req_d = 1'b0;
            cnt_d      = 16'd0;
            if (start) begin
               // A simultaneous stop forces a single-shot scan.
               state_d   = ST_CS_SETUP;
               cs_n_d    = 1'b0;
               cont_d    = continuous & ~stop;
               overrun_d = 1'b0;
               ch_d      = 3'd0;
               conv_d    = 5'd0;
               acc_d     = {ACC_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CS_SETUP: begin
            if (cnt_q == DIV_LAST) begin
               state_d = ST_SHIFT;
               cnt_d   = 16'd0;
               half_d  = 6'd0;
               din_d   = din_bit(5'd1, ch_q);
            end else begin
               state_d = ST_CS_SETUP;
            end
         end

         ST_SHIFT: begin
            // Capture two clocks after DCLK rises, once the synchroniser has settled.
            if (dclk_q && (cnt_q == 16'd1) && (half_q >= FIRST_CAP)) begin
               shift_d = {shift_q[8:0], sync2_q};
            end else begin
               shift_d = shift_q;
            end
            if (cnt_q == DIV_LAST) begin
               cnt_d = 16'd0;
               if (half_q == LAST_HALF) begin
                  state_d = ST_CS_HIGH;
                  cs_n_d  = 1'b1;
                  dclk_d  = 1'b0;
                  din_d   = 1'b0;
               end else begin
                  half_d = half_q + 6'd1;
                  dclk_d = ~dclk_q;
                  // DIN moves only on the edge that drives DCLK low.
                  if (dclk_q) begin
                     din_d = din_bit(half_q[5:1] + 5'd2, ch_q);
                  end else begin
                     din_d = din_q;
                  end
               end
            end else begin
               state_d = ST_SHIFT;
            end
         end

         ST_CS_HIGH: begin
            // The final capture of period 17 may land on the SHIFT exit edge,
            // so the sample is added during the first CS_HIGH cycle.
            if (cnt_q == 16'd0) begin
               acc_d = acc_q + ACC_W'(shift_q);
            end else begin
               acc_d = acc_q;
            end
            if (cnt_q == CSH_LAST) begin
               cnt_d = 16'd0;
               if (stop_req_q || stop) begin
                  state_d    = ST_IDLE;
                  stop_req_d = 1'b0;
                  acc_d      = {ACC_W{1'b0}};
                  conv_d     = 5'd0;
               end else if (conv_q == LAST_CONV) begin
                  state_d = ST_ACCUM;
               end else begin
                  state_d = ST_CS_SETUP;
                  cs_n_d  = 1'b0;
                  conv_d  = conv_q + 5'd1;
               end
            end else begin
               state_d = ST_CS_HIGH;
            end
         end

         ST_ACCUM: begin
            cnt_d  = 16'd0;
            acc_d  = {ACC_W{1'b0}};
            conv_d = 5'd0;
            // A pending, unaccepted result is kept; the new one is dropped.
            if (res_valid_q && !res.res_ready) begin
               overrun_d = 1'b1;
            end else begin
               res_data_d  = {ch_q, 3'b000, avg_s};
               res_valid_d = 1'b1;
            end
            if (ch_q != LAST_CH) begin
               state_d = ST_CS_SETUP;
               cs_n_d  = 1'b0;
               ch_d    = ch_q + 3'd1;
            end else if (cont_q) begin
               state_d = ST_CS_SETUP;
               cs_n_d  = 1'b0;
               ch_d    = 3'd0;
            end else begin
               state_d    = ST_IDLE;
               stop_req_d = 1'b0;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            cs_n_d     = 1'b1;
            dclk_d     = 1'b0;
            din_d      = 1'b0;
            stop_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'd0;
         half_q      <= 6'd0;
         conv_q      <= 5'd0;
         ch_q        <= 3'd0;
         acc_q       <= {ACC_W{1'b0}};
         shift_q     <= 10'd0;
         cont_q      <= 1'b0;
         stop_req_q  <= 1'b0;
         cs_n_q      <= 1'b1;
         dclk_q      <= 1'b0;
         din_q       <= 1'b0;
         busy_q      <= 1'b0;
         res_data_q  <= 16'd0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         conv_q      <= conv_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         shift_q     <= shift_d;
         cont_q      <= cont_d;
         stop_req_q  <= stop_req_d;
         cs_n_q      <= cs_n_d;
         dclk_q      <= dclk_d;
         din_q       <= din_d;
         busy_q      <= busy_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign busy          = busy_q;
   assign mcp_cs_n      = cs_n_q;
   assign mcp_dclk      = dclk_q;
   assign mcp_din       = din_q;
   assign overrun       = overrun_q;
   assign res.res_data  = res_data_q;
   assign res.res_valid = res_valid_q;

endmodule

// File: tb/tb_mcp_scan_avg.sv
// Bench for mcp_scan_avg: a behavioural MCP3008 serves per-frame values from a
// table, and expected results are the per-channel means of those values in scan order.
module tb_mcp_scan_avg;
   localparam int CLK_DIV  = 4;
   localparam int N_CH     = 3;
   localparam int AVG_LOG2 = 2;
   localparam int CSH      = 8;
   localparam int FRAME    = CLK_DIV + 34 * CLK_DIV + CSH;
   localparam int NCONV    = 1 << AVG_LOG2;
   localparam int CH_CYC   = NCONV * FRAME + 1;
   localparam int LAT      = NCONV * FRAME + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic continuous = 1'b0;
   logic stop = 1'b0;
   logic mcp_dout = 1'b0;
   logic busy, mcp_cs_n, mcp_dclk, mcp_din, overrun;

   mcp_scan_avg_if res_if ();

   mcp_scan_avg #(
      .CLK_DIV(CLK_DIV), .N_CH(N_CH), .AVG_LOG2(AVG_LOG2),
      .CS_HIGH_CYC(CSH), .SGL_DIFF(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
      .stop(stop), .busy(busy), .mcp_cs_n(mcp_cs_n), .mcp_dclk(mcp_dclk),
      .mcp_din(mcp_din), .mcp_dout(mcp_dout), .overrun(overrun), .res(res_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int t0 = 0;
   int n_checks = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: frame values, command-bit decode and frame log.
   logic [9:0] vals [0:63];
   int         bitn = 0;
   int         frame_cnt = 0;
   logic [4:0] din_bits = 5'd0;
   logic [4:0] din_log[$];
   logic [15:0] got[$];

   always @(negedge mcp_cs_n) begin
      bitn     <= 0;
      din_bits <= 5'd0;
   end

   always @(posedge mcp_dclk) begin
      if (mcp_cs_n === 1'b0) begin
         bitn <= bitn + 1;
         if (bitn < 5) din_bits <= {din_bits[3:0], mcp_din};
      end
   end

   always @(negedge mcp_dclk) begin
      if (mcp_cs_n === 1'b0 && bitn >= 7 && bitn <= 16)
         mcp_dout <= vals[6'(frame_cnt)][4'(16 - bitn)];
      else
         mcp_dout <= 1'b0;
   end

   always @(posedge mcp_cs_n) begin
      if (bitn == 17) begin
         din_log.push_back(din_bits);
         frame_cnt <= frame_cnt + 1;
      end
   end

   // Stream monitor: records each transfer.
   always @(negedge clk) begin
      if (res_if.res_valid === 1'b1 && res_if.res_ready === 1'b1)
         got.push_back(res_if.res_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result k of a scan whose first frame is 'base'.
   function automatic logic [15:0] exp_res(input int base, input int k);
      int sum;
      logic [2:0] ch;
      sum = 0;
      ch  = 3'(k % N_CH);
      for (int i = 0; i < NCONV; i++) sum += int'(vals[base + k * NCONV + i]);
      return {ch, 3'b000, 10'(sum / NCONV)};
   endfunction

   function automatic logic [4:0] exp_din(input int j);
      logic [2:0] ch;
      ch = 3'((j / NCONV) % N_CH);
      return {2'b11, ch};
   endfunction

   function automatic logic [15:0] got_at(input int idx);
      if (got.size() > idx) return got[idx];
      return 16'hxxxx;
   endfunction

   function automatic logic [4:0] din_at(input int idx);
      if (din_log.size() > idx) return din_log[idx];
      return 5'bxxxxx;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic cont);
      start = 1'b1;
      continuous = cont;
      tick();
      start = 1'b0;
      continuous = 1'b0;
      t0 = cyc;
   endtask

   task automatic run_to(input int target);
      while (cyc - t0 + 1 < target) tick();
   endtask

   task automatic wait_valid(input int limit, output int k);
      k = -1;
      for (int i = 0; i < limit && k < 0; i++) begin
         if (res_if.res_valid === 1'b1) k = cyc - t0 + 1;
         else tick();
      end
   endtask

   task automatic wait_idle(input int limit, output int k);
      k = -1;
      for (int i = 0; i < limit && k < 0; i++) begin
         if (busy === 1'b0) k = cyc - t0 + 1;
         else tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int base;
      int gbase;

      for (int i = 0; i < 64; i++) vals[i] = 10'($urandom);
      for (int i = 0; i < 4; i++) vals[i] = 10'h100 + 10'(i);
      for (int i = 4; i < 8; i++) vals[i] = 10'h3FF;
      res_if.res_ready = 1'b1;

      // Reset state.
      repeat (3) tick();
      chk("rst_cs_n", mcp_cs_n, 1'b1);
      chk("rst_dclk", mcp_dclk, 1'b0);
      chk("rst_din", mcp_din, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", res_if.res_valid, 1'b0);
      chk("rst_data", res_if.res_data, 16'h0000);
      chk("rst_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single-shot with directed averaging values and an ignored start.
      base = frame_cnt;
      gbase = got.size();
      pulse_start(1'b0);
      chk("ss_busy_c1", busy, 1'b1);
      chk("ss_cs_c1", mcp_cs_n, 1'b0);
      wait_valid(LAT + 20, k);
      chk("ss_latency", k, LAT);
      start = 1'b1;
      continuous = 1'b1;
      tick();
      start = 1'b0;
      continuous = 1'b0;
      wait_idle(N_CH * CH_CYC + 50, k);
      chk("ss_busy_fall", k, N_CH * CH_CYC + 1);
      repeat (4) tick();
      chk("ss_count", got.size() - gbase, N_CH);
      chk("ss_avg_ramp", got_at(gbase), 16'h0101);
      chk("ss_avg_full", got_at(gbase + 1), 16'h23FF);
      for (int r = 0; r < N_CH; r++) chk("ss_res", got_at(gbase + r), exp_res(base, r));
      chk("ss_frames", frame_cnt - base, N_CH * NCONV);
      for (int j = 0; j < N_CH * NCONV; j++) chk("ss_din", din_at(base + j), exp_din(j));
      chk("ss_din_ch1", din_at(base + NCONV), 5'b11001);

      // Backpressure: first result held, later ones dropped.
      res_if.res_ready = 1'b0;
      base = frame_cnt;
      gbase = got.size();
      pulse_start(1'b0);
      wait_valid(LAT + 20, k);
      chk("bp_latency", k, LAT);
      chk("bp_ovr_pre", overrun, 1'b0);
      run_to(2 * CH_CYC + 5);
      chk("bp_hold_data", res_if.res_data, exp_res(base, 0));
      chk("bp_hold_valid", res_if.res_valid, 1'b1);
      chk("bp_overrun", overrun, 1'b1);
      wait_idle(N_CH * CH_CYC + 50, k);
      chk("bp_busy_fall", k, N_CH * CH_CYC + 1);
      chk("bp_end_data", res_if.res_data, exp_res(base, 0));
      res_if.res_ready = 1'b1;
      tick();
      chk("bp_drain_valid", res_if.res_valid, 1'b0);
      chk("bp_count", got.size() - gbase, 1);
      chk("bp_res", got_at(gbase), exp_res(base, 0));

      // Continuous scan stopped mid-frame of channel 1 on the second pass.
      base = frame_cnt;
      gbase = got.size();
      pulse_start(1'b1);
      chk("cont_ovr_clear", overrun, 1'b0);
      run_to(4 * CH_CYC + FRAME + 50);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle(2 * FRAME + 50, k);
      chk("cont_busy_fall", k, 4 * CH_CYC + 2 * FRAME + 1);
      repeat (5) tick();
      chk("cont_count", got.size() - gbase, 4);
      for (int r = 0; r < 4; r++) chk("cont_res", got_at(gbase + r), exp_res(base, r));
      chk("cont_frames", frame_cnt - base, 4 * NCONV + 2);
      for (int j = 0; j < 4 * NCONV + 2; j++) chk("cont_din", din_at(base + j), exp_din(j));

      // Asynchronous reset during SHIFT period 10, then a clean restart.
      base = frame_cnt;
      pulse_start(1'b0);
      run_to(80);
      chk("mid_cs_low", mcp_cs_n, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cs", mcp_cs_n, 1'b1);
      chk("mid_rst_dclk", mcp_dclk, 1'b0);
      chk("mid_rst_din", mcp_din, 1'b0);
      chk("mid_rst_valid", res_if.res_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("mid_no_frame", frame_cnt - base, 0);
      gbase = got.size();
      pulse_start(1'b0);
      wait_valid(LAT + 20, k);
      chk("re_latency", k, LAT);
      chk("re_data", res_if.res_data, exp_res(base, 0));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle(FRAME + 50, k);
      chk("re_busy_fall", k, CH_CYC + FRAME + 1);
      repeat (3) tick();
      chk("re_count", got.size() - gbase, 1);
      chk("re_frames", frame_cnt - base, NCONV + 1);
      for (int j = 0; j < NCONV + 1; j++) chk("re_din", din_at(base + j), exp_din(j));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
